// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } ldr_state_t;

  localparam int         LEN_BYTES  = 2;
  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] CHK_SEED   = 8'h00;

endpackage

// File: rtl/le_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid is
// combinational on the accept of the 4th byte so the top can register the write.
module le_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= {byte_in, sr[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

  assign word       = {byte_in, sr};
  assign word_valid = accept && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction RAM word writer; stalls the core while busy.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int ADR_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [ADR_W-1:0] wr_adr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ldr_state_t S_FIN = S_CHK;
`else
  localparam ldr_state_t S_FIN = S_DONE;
`endif

  ldr_state_t  state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] n_words, word_cnt, n_rx;
  logic        accept, start_ok, overflow, last_word;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign n_rx      = {byte_in, len_lo};
  assign overflow  = (32'(n_rx) * 32'(WORD_BYTES)) > 32'(SIZE);
  assign last_word = (word_cnt == n_words - 16'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chk <= CHK_SEED;
    else if (start_ok)
      chk <= CHK_SEED;
    else if (state == S_LOAD && accept)
      chk <= chk ^ byte_in;
  end
`endif

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        done  = (state == S_DONE);
        error = (state == S_ERR);
        if (start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) begin
          if (overflow)          state_nxt = S_ERR;
          else if (n_rx == '0)   state_nxt = S_FIN;
          else                   state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (pk_valid && last_word) state_nxt = S_FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept) state_nxt = (byte_in == chk) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_adr   <= '0;
      wr_data  <= '0;
      len_lo   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) word_cnt <= '0;
      if (state == S_LEN_LO && accept) len_lo <= byte_in;
      if (state == S_LEN_HI && accept) n_words <= n_rx;
      // Write lands one cycle after the 4th byte of the word is accepted.
      if (pk_valid) begin
        wr_en    <= 1'b1;
        wr_adr   <= ADR_W'({word_cnt, 2'b00});
        wr_data  <= pk_word;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  le_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .accept     (accept && state == S_LOAD),
    .byte_in    (byte_in),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a stream-level model of expected RAM writes and status.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, done, error;
  logic [63:0] wr_adr;
  logic [31:0] wr_data;

  imem_loader #(.SIZE(64), .ADR_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_adr     (wr_adr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_adr[$];
  logic [31:0] exp_data[$];
  logic [63:0] log_adr[$];
  logic [31:0] log_data[$];
  logic [7:0]  pay[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Word k of the image is payload bytes 4k..4k+3, lowest byte in bits [7:0].
  function automatic logic [31:0] model_word(input int k);
    return 32'(pay[4*k]) | (32'(pay[4*k+1]) << 8) | (32'(pay[4*k+2]) << 16) | (32'(pay[4*k+3]) << 24);
  endfunction

  function automatic logic [7:0] model_xor(input int nbytes);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < nbytes; i++) x = x ^ pay[i];
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_vs_busy", 64'(byte_ready), 64'(busy));
      check("done_error_excl", 64'(done & error), 64'd0);
      if (wr_en) begin
        log_adr.push_back(wr_adr);
        log_data.push_back(wr_data);
        if (exp_adr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_adr=%0h actual_data=%0h required=none", wr_adr, wr_data);
        end else begin
          check("wr_adr", wr_adr, exp_adr.pop_front());
          check("wr_data", 64'(wr_data), 64'(exp_data.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !byte_ready; i++) @(negedge clk);
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] n, input int gap, input bit mid_start,
                          input bit chk_bad, input string tag);
    bit ovf;
    bit exp_done;
    ovf      = (int'(n) * 4) > 64;
    exp_done = !ovf;
    if (!ovf)
      for (int k = 0; k < int'(n); k++) begin
        exp_adr.push_back(64'(4 * k));
        exp_data.push_back(model_word(k));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (chk_bad) exp_done = 1'b0;
`endif
    @(negedge clk);
    pulse_start();
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_done_cleared"}, 64'(done | error), 64'd0);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    if (!ovf) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        send_byte(pay[i], gap);
        if (mid_start && i == 2) pulse_start();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(chk_bad ? 8'h00 : model_xor(4 * int'(n)), gap);
`endif
    end
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(!exp_done));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_ready_end"}, 64'(byte_ready), 64'd0);
    check({tag, "_writes_pending"}, 64'(exp_adr.size()), 64'd0);
    exp_adr.delete();
    exp_data.delete();
  endtask

  task automatic check_image2(input string tag);
    check({tag, "_nwrites"}, 64'(log_adr.size()), 64'd2);
    if (log_adr.size() == 2) begin
      check({tag, "_adr0"}, log_adr[0], 64'h0);
      check({tag, "_dat0"}, 64'(log_data[0]), 64'h003100B3);
      check({tag, "_adr1"}, log_adr[1], 64'h4);
      check({tag, "_dat1"}, 64'(log_data[1]), 64'h0062F233);
    end
    log_adr.delete();
    log_data.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_adr"}, wr_adr, 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pay = '{8'hB3, 8'h00, 8'h31, 8'h00, 8'h33, 8'hF2, 8'h62, 8'h00};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    check("model_w0", 64'(model_word(0)), 64'h003100B3);
    check("model_w1", 64'(model_word(1)), 64'h0062F233);
    check("model_xor", 64'(model_xor(8)), 64'h21);

    run_load(16'd2, 0, 1'b0, 1'b0, "t1");
    check_image2("t1");

    run_load(16'd17, 0, 1'b0, 1'b0, "t2");
    check("t2_nwrites", 64'(log_adr.size()), 64'd0);
    log_adr.delete();
    log_data.delete();

    run_load(16'd2, 3, 1'b0, 1'b0, "t3");
    check_image2("t3");

    // Abort mid-load after the first word and two bytes of the second.
    exp_adr.push_back(64'h0);
    exp_data.push_back(model_word(0));
    @(negedge clk);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_nwrites", 64'(log_adr.size()), 64'd1);
    if (log_adr.size() == 1) check("t4_adr0", log_adr[0], 64'h0);
    check("t4_pending", 64'(exp_adr.size()), 64'd0);
    exp_adr.delete();
    exp_data.delete();
    log_adr.delete();
    log_data.delete();
    run_load(16'd2, 0, 1'b0, 1'b0, "t4b");
    check_image2("t4b");

    run_load(16'd2, 0, 1'b1, 1'b0, "t5");
    check_image2("t5");
    run_load(16'd0, 0, 1'b0, 1'b0, "t5z");
    check("t5z_nwrites", 64'(log_adr.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(16'd2, 0, 1'b0, 1'b1, "t6bad");
    check_image2("t6bad");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
